// File: rtl/cpu_sram_arbiter.sv
// cpu_sram_arbiter
//   Serialises the CPU instruction-fetch and data-access channels onto one
//   synchronous single-port SRAM with 1-cycle read latency. The data channel
//   has priority. A starvation counter forces a pending fetch to win after
//   STARVE_LIMIT consecutive lost cycles. One access can issue per cycle, and
//   the response for cycle N overlaps with the issue in cycle N+1.
//
// Ports
//   clk, resetn                      clock, synchronous active-low reset
//   inst_req/addr                    fetch request (word-aligned byte address)
//   inst_addr_ok/data_ok/rdata       fetch accept, response valid, fetched word
//   data_req/wr/size/addr/wdata      data request (store data lane-positioned)
//   data_addr_ok/data_ok/rdata       data accept, response valid, loaded word
//   sram_en/wen/addr/wdata           SRAM command (word address)
//   sram_rdata                       SRAM read data, valid the cycle after sram_en
module cpu_sram_arbiter #(
    parameter int unsigned ADDR_W       = 16,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              inst_req,
    input  logic [31:0]       inst_addr,
    output logic              inst_addr_ok,
    output logic              inst_data_ok,
    output logic [31:0]       inst_rdata,
    input  logic              data_req,
    input  logic              data_wr,
    input  logic [1:0]        data_size,
    input  logic [31:0]       data_addr,
    input  logic [31:0]       data_wdata,
    output logic              data_addr_ok,
    output logic              data_data_ok,
    output logic [31:0]       data_rdata,
    output logic              sram_en,
    output logic [3:0]        sram_wen,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [31:0]       sram_wdata,
    input  logic [31:0]       sram_rdata
);

    typedef enum logic [1:0] {
        RESP_NONE = 2'd0,
        RESP_INST = 2'd1,
        RESP_DATA = 2'd2
    } resp_t;

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    resp_t      resp_sel, resp_sel_nxt;
    logic [3:0] starve_cnt, starve_cnt_nxt;
    logic       force_inst, grant_data, grant_inst;
    logic [3:0] store_wen;

    // Address bits outside the SRAM word range are intentionally ignored.
    logic unused_addr_bits;
    assign unused_addr_bits = &{1'b0, inst_addr[31:ADDR_W+2], inst_addr[1:0],
                                data_addr[31:ADDR_W+2]};

    // Byte enables for a store; misaligned or reserved sizes write nothing.
    always_comb begin
        store_wen = '0;
        unique case (data_size)
            2'd0: store_wen = 4'b0001 << data_addr[1:0];
            2'd1: begin
                if (!data_addr[0]) begin
                    store_wen = data_addr[1] ? 4'b1100 : 4'b0011;
                end
            end
            2'd2: begin
                if (data_addr[1:0] == 2'b00) begin
                    store_wen = 4'b1111;
                end
            end
            default: store_wen = '0;
        endcase
    end

    // Arbitration, issue, response routing and starvation tracking. Grants and
    // responses are masked while resetn is low so a response that was pending
    // when reset arrived never surfaces.
    always_comb begin
        force_inst     = resetn & inst_req & (starve_cnt == LIMIT);
        grant_data     = resetn & data_req & ~force_inst;
        grant_inst     = resetn & inst_req & ~grant_data;

        inst_addr_ok   = grant_inst;
        data_addr_ok   = grant_data;

        sram_en        = grant_data | grant_inst;
        sram_wen       = (grant_data & data_wr) ? store_wen : 4'b0000;
        sram_wdata     = data_wdata;
        sram_addr      = '0;
        if (grant_data) begin
            sram_addr = data_addr[ADDR_W+1:2];
        end else if (grant_inst) begin
            sram_addr = inst_addr[ADDR_W+1:2];
        end

        inst_data_ok   = resetn & (resp_sel == RESP_INST);
        data_data_ok   = resetn & (resp_sel == RESP_DATA);
        inst_rdata     = inst_data_ok ? sram_rdata : 32'h0;
        data_rdata     = data_data_ok ? sram_rdata : 32'h0;

        resp_sel_nxt   = RESP_NONE;
        if (grant_data) begin
            resp_sel_nxt = RESP_DATA;
        end else if (grant_inst) begin
            resp_sel_nxt = RESP_INST;
        end

        starve_cnt_nxt = starve_cnt;
        if (!inst_req || grant_inst) begin
            starve_cnt_nxt = '0;
        end else if (starve_cnt != LIMIT) begin
            starve_cnt_nxt = starve_cnt + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            resp_sel   <= RESP_NONE;
            starve_cnt <= '0;
        end else begin
            resp_sel   <= resp_sel_nxt;
            starve_cnt <= starve_cnt_nxt;
        end
    end

endmodule

// File: tb/tb_cpu_sram_arbiter.sv
module tb_cpu_sram_arbiter;

    localparam int LIMIT = 4;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        inst_req = 1'b0;
    logic [31:0] inst_addr = '0;
    logic        inst_addr_ok, inst_data_ok;
    logic [31:0] inst_rdata;
    logic        data_req = 1'b0, data_wr = 1'b0;
    logic [1:0]  data_size = '0;
    logic [31:0] data_addr = '0, data_wdata = '0;
    logic        data_addr_ok, data_data_ok;
    logic [31:0] data_rdata;
    logic        sram_en;
    logic [3:0]  sram_wen;
    logic [15:0] sram_addr;
    logic [31:0] sram_wdata;
    logic [31:0] sram_rdata = '0;

    int checks = 0;
    int failures = 0;
    bit run = 1'b0;

    always #5 clk = ~clk;

    cpu_sram_arbiter #(.ADDR_W(16), .STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .resetn(resetn),
        .inst_req(inst_req), .inst_addr(inst_addr),
        .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_addr(data_addr), .data_wdata(data_wdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .sram_en(sram_en), .sram_wen(sram_wen), .sram_addr(sram_addr),
        .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
    );

    function automatic logic [31:0] init_word(int i);
        return 32'hC0DE0000 | 32'(i);
    endfunction

    // SRAM: 256 words, read-before-write, data one cycle after sram_en.
    logic [31:0] mem [256];
    bit          mem_loaded = 1'b0;
    always @(posedge clk) begin
        if (!mem_loaded) begin
            for (int i = 0; i < 256; i++) mem[i] <= init_word(i);
            mem_loaded <= 1'b1;
        end else if (sram_en) begin
            sram_rdata <= mem[sram_addr[7:0]];
            for (int b = 0; b < 4; b++)
                if (sram_wen[b]) mem[sram_addr[7:0]][8*b +: 8] <= sram_wdata[8*b +: 8];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h want=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Store mask from access width: an n-byte access must be n-aligned.
    function automatic logic [3:0] model_wen(logic [1:0] sz, logic [31:0] a);
        int n, off;
        if (sz == 2'd3) return 4'b0000;
        n   = 1 << sz;
        off = int'(a[1:0]);
        if (off % n != 0) return 4'b0000;
        return 4'(((1 << n) - 1) << off);
    endfunction

    // Reference model: memory contents, the response owed next cycle, and the
    // number of consecutive cycles a waiting fetch has lost.
    logic [31:0] ref_mem [256];
    bit          ref_loaded = 1'b0;
    int          pend_kind = 0;   // 0 none, 1 fetch, 2 data
    bit          pend_store = 1'b0;
    logic [31:0] pend_word = '0;
    int          losses = 0;

    always @(negedge clk) begin
        bit          f, gd, gi, iok, dok;
        logic [3:0]  ew;
        logic [15:0] ea;
        int          idx;
        if (!ref_loaded) begin
            for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
            ref_loaded = 1'b1;
        end
        if (run) begin
            f  = resetn && inst_req && (losses == LIMIT);
            gd = resetn && data_req && !f;
            gi = resetn && inst_req && !gd;
            ew = (gd && data_wr) ? model_wen(data_size, data_addr) : 4'b0000;
            ea = gd ? data_addr[17:2] : (gi ? inst_addr[17:2] : 16'h0);
            iok = resetn && (pend_kind == 1);
            dok = resetn && (pend_kind == 2);

            chk("inst_addr_ok", 32'(inst_addr_ok), 32'(gi));
            chk("data_addr_ok", 32'(data_addr_ok), 32'(gd));
            chk("sram_en", 32'(sram_en), 32'(gd || gi));
            chk("sram_wen", 32'(sram_wen), 32'(ew));
            chk("sram_addr", 32'(sram_addr), 32'(ea));
            chk("sram_wdata", sram_wdata, data_wdata);
            chk("inst_data_ok", 32'(inst_data_ok), 32'(iok));
            chk("data_data_ok", 32'(data_data_ok), 32'(dok));
            chk("inst_rdata", inst_rdata, iok ? pend_word : 32'h0);
            if (!dok) chk("data_rdata_idle", data_rdata, 32'h0);
            else if (!pend_store) chk("data_rdata", data_rdata, pend_word);

            if (!resetn) begin
                pend_kind = 0;
                losses    = 0;
            end else begin
                idx        = int'(ea[7:0]);
                pend_kind  = gi ? 1 : (gd ? 2 : 0);
                pend_store = gd && data_wr;
                pend_word  = ref_mem[idx];
                for (int b = 0; b < 4; b++)
                    if (ew[b]) ref_mem[idx][8*b +: 8] = data_wdata[8*b +: 8];
                if (inst_req && !gi) losses = (losses + 1 > LIMIT) ? LIMIT : losses + 1;
                else losses = 0;
            end
        end
    end

    // Apply one cycle of inputs just after the rising edge.
    task automatic drive(input logic rn, input logic ir, input logic [31:0] ia,
                         input logic dr, input logic dw, input logic [1:0] ds,
                         input logic [31:0] da, input logic [31:0] dwd);
        @(posedge clk);
        #1;
        run        = 1'b1;
        resetn     = rn;
        inst_req   = ir;
        inst_addr  = ia;
        data_req   = dr;
        data_wr    = dw;
        data_size  = ds;
        data_addr  = da;
        data_wdata = dwd;
        #2;
    endtask

    task automatic idle();
        drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
    endtask

    task automatic store(input logic [1:0] sz, input logic [31:0] a, input logic [3:0] exp_wen);
        drive(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, sz, a, 32'hAABBCCDD);
        chk("lit_store_wen", 32'(sram_wen), 32'(exp_wen));
        chk("lit_store_ack", 32'(data_addr_ok), 32'd1);
    endtask

    initial begin
        // Reset held with a fetch pending: nothing may be accepted.
        for (int k = 0; k < 2; k++) begin
            drive(1'b0, 1'b1, 32'h10, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
            chk("lit_rst_addr_ok", 32'(inst_addr_ok), 32'd0);
            chk("lit_rst_sram_en", 32'(sram_en), 32'd0);
        end
        drive(1'b1, 1'b1, 32'h10, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
        chk("lit_fetch_ok", 32'(inst_addr_ok), 32'd1);
        chk("lit_fetch_addr", 32'(sram_addr), 32'h4);
        idle();
        chk("lit_fetch_data_ok", 32'(inst_data_ok), 32'd1);
        chk("lit_fetch_rdata", inst_rdata, 32'hC0DE0004);

        // Store byte enables, including suppressed misaligned/reserved cases.
        store(2'd0, 32'h103, 4'b1000);
        store(2'd1, 32'h102, 4'b1100);
        store(2'd0, 32'h100, 4'b0001);
        store(2'd1, 32'h100, 4'b0011);
        store(2'd1, 32'h101, 4'b0000);
        store(2'd3, 32'h100, 4'b0000);
        store(2'd2, 32'h101, 4'b0000);
        idle();
        chk("lit_misaligned_data_ok", 32'(data_data_ok), 32'd1);
        idle();

        // Priority with starvation guard.
        for (int k = 0; k < 6; k++) begin
            drive(1'b1, 1'b1, 32'h20, 1'b1, 1'b0, 2'd2, 32'h200, 32'h0);
            chk("lit_prio_inst", 32'(inst_addr_ok), (k == 4) ? 32'd1 : 32'd0);
            chk("lit_prio_data", 32'(data_addr_ok), (k == 4) ? 32'd0 : 32'd1);
        end
        idle();
        idle();

        // Back-to-back load, load, store, then read the stored word back.
        drive(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 2'd2, 32'h300, 32'h0);
        chk("lit_b2b_en0", 32'(sram_en), 32'd1);
        drive(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 2'd2, 32'h304, 32'h0);
        chk("lit_b2b_en1", 32'(sram_en), 32'd1);
        chk("lit_b2b_rdata0", data_rdata, 32'hC0DE00C0);
        drive(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 2'd2, 32'h308, 32'h12345678);
        chk("lit_b2b_en2", 32'(sram_en), 32'd1);
        chk("lit_b2b_rdata1", data_rdata, 32'hC0DE00C1);
        drive(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 2'd2, 32'h308, 32'h0);
        chk("lit_b2b_store_ok", 32'(data_data_ok), 32'd1);
        idle();
        chk("lit_b2b_readback", data_rdata, 32'h12345678);

        // Interleaved routing: data load then fetch.
        drive(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 2'd2, 32'h40, 32'h0);
        drive(1'b1, 1'b1, 32'h44, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
        chk("lit_il_data_ok", 32'(data_data_ok), 32'd1);
        chk("lit_il_inst_ok0", 32'(inst_data_ok), 32'd0);
        chk("lit_il_data_rdata", data_rdata, 32'hC0DE0010);
        idle();
        chk("lit_il_inst_ok", 32'(inst_data_ok), 32'd1);
        chk("lit_il_data_ok1", 32'(data_data_ok), 32'd0);
        chk("lit_il_inst_rdata", inst_rdata, 32'hC0DE0011);
        idle();

        // Reset mid-operation with a pending load and a partly advanced counter.
        for (int k = 0; k < 2; k++)
            drive(1'b1, 1'b1, 32'h60, 1'b1, 1'b0, 2'd2, 32'h50, 32'h0);
        drive(1'b0, 1'b1, 32'h60, 1'b1, 1'b0, 2'd2, 32'h50, 32'h0);
        chk("lit_midrst_data_ok", 32'(data_data_ok), 32'd0);
        chk("lit_midrst_addr_ok", 32'(data_addr_ok), 32'd0);
        for (int k = 0; k < 5; k++) begin
            drive(1'b1, 1'b1, 32'h60, 1'b1, 1'b0, 2'd2, 32'h50, 32'h0);
            chk("lit_postrst_inst", 32'(inst_addr_ok), (k == 4) ? 32'd1 : 32'd0);
            if (k == 0) chk("lit_postrst_data_ok", 32'(data_data_ok), 32'd0);
        end
        idle();
        idle();
        idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cpu_sram_arbiter.md
Name: cpu_sram_arbiter

Overview:
- Sits directly downstream of the five-stage CPU top.
- Accepts the CPU's instruction-fetch and data-access requests on two independent request/ack channels and serialises them onto one synchronous single-port SRAM with 1-cycle read latency.
- Data-side requests have priority over fetches, with a starvation guard so fetches still make progress.
- Fully pipelined: up to one memory access issued per cycle.

Parameters:
- ADDR_W, 16, word-address width driven to the SRAM (byte address bits [ADDR_W+1:2] are used).
- STARVE_LIMIT, 4, consecutive cycles a pending fetch may lose arbitration before it is forced to win; range 1..15.

Ports:
- clk  in  1  clock
- resetn  in  1  synchronous active-low reset
- inst_req  in  1  fetch request valid
- inst_addr  in  32  fetch byte address, word aligned
- inst_addr_ok  out  1  fetch accepted this cycle
- inst_data_ok  out  1  fetch data valid
- inst_rdata  out  32  fetched word
- data_req  in  1  data request valid
- data_wr  in  1  1=store, 0=load
- data_size  in  2  0=byte, 1=half, 2=word, 3=reserved
- data_addr  in  32  data byte address
- data_wdata  in  32  store data, already lane-positioned by the CPU
- data_addr_ok  out  1  data request accepted this cycle
- data_data_ok  out  1  load data valid / store completed
- data_rdata  out  32  loaded word (unshifted)
- sram_en  out  1  SRAM access enable
- sram_wen  out  4  SRAM byte write enables
- sram_addr  out  ADDR_W  SRAM word address
- sram_wdata  out  32  SRAM write data
- sram_rdata  in  32  SRAM read data, valid the cycle after sram_en

Behaviour:
- Reset (resetn=0 at posedge):
  - Clears the response-route register (resp_sel = NONE) and the starvation counter.
  - All outputs are combinationally 0 while resp_sel=NONE and no request is present.
  - A response pending at reset is dropped: no data_ok follows.
- Arbitration (combinational, same cycle):
  - grant_data = data_req & ~force_inst.
  - grant_inst = inst_req & ~grant_data.
  - force_inst = inst_req & (starve_cnt == STARVE_LIMIT).
  - Exactly one of addr_ok is asserted when granted.
  - A channel holds req and address/data stable until its addr_ok.
- Issue:
  - sram_en = grant_data | grant_inst.
  - sram_addr comes from the granted channel.
  - sram_wdata = data_wdata.
  - sram_wen = 0 unless grant_data & data_wr.
- Byte enables for stores:
  - size 0: wen = 1 << addr[1:0].
  - size 1: wen = 0011 if addr[1]=0, 1100 if addr[1]=1.
  - size 2: wen = 1111.
  - Misaligned cases (size 1 with addr[0]=1; size 2 with addr[1:0]!=0) and size 3: wen = 0000 (store suppressed) but still acked normally.
- Response (1-cycle latency):
  - resp_sel <= INST/DATA/NONE according to the grant.
  - In the next cycle the selected channel's data_ok=1 and its rdata = sram_rdata.
  - Stores also produce data_data_ok; data_rdata is don't-care for stores.
  - The other channel's data_ok=0; rdata outputs are 0 when not selected.
- Back-to-back operation: an issue in cycle N and an issue in cycle N+1 are both legal. Cycle N+1 carries the response for N and the new issue simultaneously.
- Starvation counter (4-bit):
  - Increments when inst_req=1 and grant_inst=0.
  - Clears when grant_inst=1 or inst_req=0.
  - Saturates at STARVE_LIMIT.
- Simultaneous requests below the limit: data wins; inst_addr_ok=0.
- Request dropped before ack: legal; no state change beyond the counter clear.

Test Plan:
- Reset then idle: hold resetn=0 2 cycles with inst_req=1 -> no addr_ok, sram_en=0. After release, inst_req=1, addr 0x00000010 -> inst_addr_ok same cycle, sram_addr=4, inst_data_ok next cycle with inst_rdata = SRAM word.
- Store byte enables: data_wr=1, data_size=0, addr 0x103 -> sram_wen=1000. Size 1, addr 0x102 -> 1100. Size 2, addr 0x101 -> 0000, and data_data_ok still asserted one cycle later.
- Priority: inst_req and data_req both held, STARVE_LIMIT=4 -> data wins cycles 0-3. Cycle 4: inst_addr_ok=1, data_addr_ok=0. Counter clears, data resumes winning.
- Back-to-back: load, load, store on 3 consecutive cycles -> sram_en high 3 cycles, data_data_ok high cycles 1-3, rdata from the first two loads matches preloaded SRAM.
- Interleaved routing: issue data load in cycle 0 and fetch in cycle 1 -> cycle 1 has only data_data_ok, cycle 2 has only inst_data_ok, each with the correct word.
- Reset mid-operation: accept a load in cycle 0, assert resetn=0 at cycle 1 posedge -> no data_data_ok in cycle 1 or later; counter reads 0 after release.
